i2c_slave: RTL and testbench

- I2C target (responder) matching the bus driven by the team's I2C master (i2c_scl, i2c_sda).
- Oversamples SCL/SDA on the system clock, detects START and STOP, and matches a fixed 7-bit address.
- Receives write bytes onto a byte-valid output and supplies read bytes through a request strobe.
- Drives SDA open-drain only (pull-low enable); no clock stretching.

---
 rtl/i2c_slave.sv | 186 ++++++++++++++++++
 tb/tb_i2c_slave.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target: oversampled SCL/SDA, START/STOP detection, fixed 7-bit address match,
// write bytes out on rx_valid, read bytes fetched through tx_req. Open-drain SDA, no stretching.
module i2c_slave #(
    parameter int unsigned             ADDR_WIDTH = 7,
    parameter int unsigned             DATA_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0]   SLAVE_ADDR = 7'h50
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i2c_scl,
    input  logic                  i2c_sda,
    output logic                  i2c_sda_oe,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  tx_req,
    output logic                  busy
);

    localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
    localparam logic [CntW-1:0] One      = CntW'(1);
    localparam logic [CntW-1:0] AddrLast = CntW'(ADDR_WIDTH);
    localparam logic [CntW-1:0] AddrBits = CntW'(ADDR_WIDTH + 1);
    localparam logic [CntW-1:0] DataLast = CntW'(DATA_WIDTH - 1);
    localparam logic [CntW-1:0] DataBits = CntW'(DATA_WIDTH);

    typedef enum logic [2:0] {
        StIdle, StAddr, StAddrAck, StWrite, StWriteAck, StRead, StReadAck, StIgnore
    } state_e;

    logic [1:0]            scl_sync_q, sda_sync_q;
    logic                  scl_prev_q, sda_prev_q;
    state_e                state_q;
    logic [CntW-1:0]       cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  rw_q;
    logic                  oe_q;
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  tx_req_q;
    logic                  busy_q;

    logic                  scl_s, sda_s;
    logic                  start_ev, stop_ev, sample_ev, shift_ev;
    logic [DATA_WIDTH-1:0] shifted;

    assign scl_s     = scl_sync_q[1];
    assign sda_s     = sda_sync_q[1];
    assign start_ev  = sda_prev_q & ~sda_s & scl_s & scl_prev_q;
    assign stop_ev   = ~sda_prev_q & sda_s & scl_s & scl_prev_q;
    assign sample_ev = scl_s & ~scl_prev_q;
    assign shift_ev  = ~scl_s & scl_prev_q;
    assign shifted   = {shift_q[DATA_WIDTH-2:0], sda_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            // Sync flops reset to the idle bus level so no false edge follows reset
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= '0;
            shift_q    <= '0;
            rw_q       <= 1'b0;
            oe_q       <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            scl_sync_q <= {scl_sync_q[0], i2c_scl};
            sda_sync_q <= {sda_sync_q[0], i2c_sda};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
            rx_valid_q <= 1'b0;
            tx_req_q   <= 1'b0;

            // tx_data is taken while tx_req is high; bit 7 goes out right away
            if (tx_req_q) begin
                shift_q <= tx_data;
                oe_q    <= ~tx_data[DATA_WIDTH-1];
            end

            if (stop_ev) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                oe_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else if (start_ev) begin
                state_q <= StAddr;
                cnt_q   <= '0;
                oe_q    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                    end
                    StAddr: begin
                        if (sample_ev && cnt_q < AddrBits) begin
                            shift_q <= shifted;
                            cnt_q   <= cnt_q + One;
                            if (cnt_q == AddrLast) begin
                                rw_q <= shifted[0];
                                if (shifted[ADDR_WIDTH:1] == SLAVE_ADDR) begin
                                    busy_q <= 1'b1;
                                end else begin
                                    busy_q  <= 1'b0;
                                    state_q <= StIgnore;
                                end
                            end
                        end else if (shift_ev && cnt_q == AddrBits) begin
                            oe_q    <= 1'b1;
                            state_q <= StAddrAck;
                        end
                    end
                    StAddrAck: begin
                        if (shift_ev) begin
                            if (rw_q) begin
                                tx_req_q <= 1'b1;
                                cnt_q    <= One;
                                state_q  <= StRead;
                            end else begin
                                oe_q    <= 1'b0;
                                cnt_q   <= '0;
                                state_q <= StWrite;
                            end
                        end
                    end
                    StWrite: begin
                        if (sample_ev && cnt_q < DataBits) begin
                            shift_q <= shifted;
                            cnt_q   <= cnt_q + One;
                            if (cnt_q == DataLast) begin
                                rx_data_q  <= shifted;
                                rx_valid_q <= 1'b1;
                            end
                        end else if (shift_ev && cnt_q == DataBits) begin
                            oe_q    <= 1'b1;
                            state_q <= StWriteAck;
                        end
                    end
                    StWriteAck: begin
                        if (shift_ev) begin
                            oe_q    <= 1'b0;
                            cnt_q   <= '0;
                            state_q <= StWrite;
                        end
                    end
                    StRead: begin
                        if (shift_ev) begin
                            if (cnt_q == DataBits) begin
                                oe_q    <= 1'b0;
                                state_q <= StReadAck;
                            end else begin
                                oe_q    <= ~shift_q[DATA_WIDTH-2];
                                shift_q <= {shift_q[DATA_WIDTH-2:0], 1'b0};
                                cnt_q   <= cnt_q + One;
                            end
                        end
                    end
                    StReadAck: begin
                        if (sample_ev) begin
                            if (sda_s) begin
                                state_q <= StIgnore;
                            end
                        end else if (shift_ev) begin
                            tx_req_q <= 1'b1;
                            cnt_q    <= One;
                            state_q  <= StRead;
                        end
                    end
                    StIgnore: begin
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign i2c_sda_oe = oe_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_req     = tx_req_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bus-level master model drives SCL/SDA; expectations come from
// transaction-level rules (address match, byte lists), including randomized transfers.
module tb_i2c_slave;

    localparam int Q = 8;  // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset;
    logic       scl;
    logic       sda_m;
    logic       sda_bus;
    logic       oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data;
    logic       tx_req;
    logic       busy;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] rx_q[$];
    int         tx_req_cnt = 0;
    int         both_cnt = 0;
    logic       oe_seen = 1'b0;

    assign sda_bus = sda_m & ~oe;

    i2c_slave dut (
        .clk       (clk),
        .reset     (reset),
        .i2c_scl   (scl),
        .i2c_sda   (sda_bus),
        .i2c_sda_oe(oe),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .tx_data   (tx_data),
        .tx_req    (tx_req),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) rx_q.push_back(rx_data);
        if (tx_req) tx_req_cnt++;
        if (rx_valid && tx_req) both_cnt++;
        if (oe) oe_seen = 1'b1;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wq();
        repeat (Q) @(negedge clk);
    endtask

    task automatic m_start();
        if (!scl) begin
            wq(); sda_m = 1'b1; wq(); scl = 1'b1; wq(); wq();
        end
        sda_m = 1'b0; wq(); wq(); scl = 1'b0;
    endtask

    task automatic m_stop();
        wq(); sda_m = 1'b0; wq(); scl = 1'b1; wq(); wq(); sda_m = 1'b1;
    endtask

    task automatic m_bit(input logic b, output logic rd);
        wq(); sda_m = b; wq(); scl = 1'b1; wq(); rd = sda_bus; wq(); scl = 1'b0;
    endtask

    task automatic m_write_byte(input logic [7:0] d, output logic acked);
        logic r;
        for (int i = 7; i >= 0; i--) m_bit(d[i], r);
        m_bit(1'b1, r);
        acked = ~r;
    endtask

    task automatic m_read_byte(input logic master_ack, input logic load_next,
                               input logic [7:0] next_tx, output logic [7:0] d);
        logic r;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            m_bit(1'b1, r);
            d = {d[6:0], r};
        end
        if (load_next) tx_data = next_tx;
        m_bit(~master_ack, r);
    endtask

    task automatic test_reset();
        reset = 1'b1; scl = 1'b1; sda_m = 1'b1; tx_data = '0;
        repeat (3) @(negedge clk);
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL reset_oe got %b want 0", oe); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (tx_req !== 1'b0) begin errors++; $display("FAIL reset_tx_req got %b want 0", tx_req); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        reset = 1'b0;
        wq();
    endtask

    task automatic test_write();
        logic a;
        rx_q.delete();
        m_start();
        m_write_byte(8'hA0, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL write_addr_ack got %b want 1", a); end
        m_write_byte(8'hA5, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL write_d0_ack got %b want 1", a); end
        m_write_byte(8'h3C, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL write_d1_ack got %b want 1", a); end
        m_stop();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_before_stop_latency got %b want 1", busy); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_stop got %b want 0", busy); end
        wq();
        checks++;
        if (rx_q.size() != 2 || rx_q[0] !== 8'hA5 || rx_q[1] !== 8'h3C) begin
            errors++;
            $display("FAIL write_rx got %p want '{a5,3c}", rx_q);
        end
    endtask

    task automatic test_nomatch();
        logic a;
        rx_q.delete();
        oe_seen = 1'b0;
        m_start();
        m_write_byte(8'hA2, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL nomatch_addr_ack got %b want 0", a); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL nomatch_busy got %b want 0", busy); end
        m_write_byte(8'hFF, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL nomatch_data_ack got %b want 0", a); end
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL nomatch_oe_seen got %b want 0", oe_seen); end
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL nomatch_rx_count got %0d want 0", rx_q.size()); end
        m_start();
        m_write_byte(8'hA0, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rstart_match_ack got %b want 1", a); end
        m_write_byte(8'h5E, a);
        m_stop(); wq();
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h5E) begin
            errors++; $display("FAIL after_nomatch_rx got %p want '{5e}", rx_q);
        end
    endtask

    task automatic test_read();
        logic a;
        logic [7:0] d;
        tx_data = 8'hC3;
        tx_req_cnt = 0;
        m_start();
        m_write_byte(8'hA1, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL read_addr_ack got %b want 1", a); end
        m_read_byte(1'b1, 1'b1, 8'h5A, d);
        checks++; if (d !== 8'hC3) begin errors++; $display("FAIL read_b0 got %h want c3", d); end
        m_read_byte(1'b0, 1'b0, 8'h00, d);
        checks++; if (d !== 8'h5A) begin errors++; $display("FAIL read_b1 got %h want 5a", d); end
        wq();
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL read_release_after_nack got %b want 0", oe); end
        checks++; if (tx_req_cnt != 2) begin errors++; $display("FAIL read_tx_req_count got %0d want 2", tx_req_cnt); end
        m_stop(); wq();
    endtask

    task automatic test_rstart();
        logic a;
        logic [7:0] d;
        rx_q.delete();
        tx_req_cnt = 0;
        m_start();
        m_write_byte(8'hA0, a);
        m_write_byte(8'h12, a);
        tx_data = 8'h9B;
        m_start();
        m_write_byte(8'hA1, a);
        checks++; if (a !== 1'b1) begin errors++; $display("FAIL rstart_readdr_ack got %b want 1", a); end
        m_read_byte(1'b0, 1'b0, 8'h00, d);
        checks++; if (d !== 8'h9B) begin errors++; $display("FAIL rstart_read got %h want 9b", d); end
        checks++; if (tx_req_cnt != 1) begin errors++; $display("FAIL rstart_tx_req got %0d want 1", tx_req_cnt); end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 8'h12) begin
            errors++; $display("FAIL rstart_rx got %p want '{12}", rx_q);
        end
        m_stop(); wq();
    endtask

    task automatic test_partial_stop();
        logic a, r;
        rx_q.delete();
        m_start();
        m_write_byte(8'hA0, a);
        m_bit(1'b1, r); m_bit(1'b0, r); m_bit(1'b1, r); m_bit(1'b0, r);
        m_stop(); wq();
        checks++; if (rx_q.size() != 0) begin errors++; $display("FAIL partial_rx_count got %0d want 0", rx_q.size()); end
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL partial_oe got %b want 0", oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL partial_busy got %b want 0", busy); end
    endtask

    task automatic test_reset_during_ack();
        logic a, r;
        logic [7:0] addr_byte;
        addr_byte = 8'hA0;
        m_start();
        for (int i = 7; i >= 0; i--) m_bit(addr_byte[i], r);
        wq(); sda_m = 1'b1; wq(); scl = 1'b1; wq();
        checks++; if (oe !== 1'b1) begin errors++; $display("FAIL rst_ack_driving got %b want 1", oe); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++; if (oe !== 1'b0) begin errors++; $display("FAIL rst_ack_oe got %b want 0", oe); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_ack_busy got %b want 0", busy); end
        oe_seen = 1'b0;
        wq(); scl = 1'b0;
        m_write_byte(8'h77, a);
        checks++; if (a !== 1'b0) begin errors++; $display("FAIL rst_no_ack got %b want 0", a); end
        checks++; if (oe_seen !== 1'b0) begin errors++; $display("FAIL rst_oe_seen got %b want 0", oe_seen); end
        m_stop(); wq();
    endtask

    task automatic test_random();
        for (int k = 0; k < 8; k++) begin
            logic       is_read, match, a;
            logic [6:0] addr;
            logic [7:0] bytes[$];
            logic [7:0] exp_rx[$];
            logic [7:0] d;
            int         n;
            is_read = 1'($urandom_range(0, 1));
            addr    = ($urandom_range(0, 2) != 0) ? 7'h50 : 7'($urandom);
            match   = (addr == 7'h50);
            n       = $urandom_range(1, 3);
            bytes.delete();
            for (int i = 0; i < n; i++) bytes.push_back(8'($urandom));
            rx_q.delete();
            tx_req_cnt = 0;
            if (is_read) tx_data = bytes[0];
            m_start();
            m_write_byte({addr, is_read}, a);
            checks++;
            if (a !== match) begin errors++; $display("FAIL rand%0d_addr_ack got %b want %b", k, a, match); end
            for (int i = 0; i < n; i++) begin
                if (is_read) begin
                    m_read_byte(i != n - 1, i != n - 1, (i != n - 1) ? bytes[i+1] : 8'h00, d);
                    checks++;
                    if (d !== (match ? bytes[i] : 8'hFF)) begin
                        errors++;
                        $display("FAIL rand%0d_read%0d got %h want %h", k, i, d, match ? bytes[i] : 8'hFF);
                    end
                end else begin
                    m_write_byte(bytes[i], a);
                    checks++;
                    if (a !== match) begin errors++; $display("FAIL rand%0d_wack%0d got %b want %b", k, i, a, match); end
                end
            end
            m_stop(); wq();
            if (is_read) begin
                checks++;
                if (tx_req_cnt != (match ? n : 0)) begin
                    errors++; $display("FAIL rand%0d_tx_req got %0d want %0d", k, tx_req_cnt, match ? n : 0);
                end
            end else begin
                exp_rx.delete();
                if (match) exp_rx = bytes;
                checks++;
                if (rx_q != exp_rx) begin
                    errors++; $display("FAIL rand%0d_rx got %p want %p", k, rx_q, exp_rx);
                end
            end
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (both_cnt != 0) begin errors++; $display("FAIL rx_valid_tx_req_overlap got %0d want 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_nomatch();
        test_read();
        test_rstart();
        test_partial_stop();
        test_reset_during_ack();
        test_random();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
